// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO pointer logic.
//   FIFO_ADDRSIZE : default memory address width
//   PTR_W         : pointer width (one extra wrap bit over the address)
//   FIFO_DEPTH    : number of memory entries
//   ptr_t         : pointer type for the default configuration
//   bin2gray()    : binary to reflected Gray code conversion
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned FIFO_ADDRSIZE = 4;
   localparam int unsigned PTR_W         = FIFO_ADDRSIZE + 1;
   localparam int unsigned FIFO_DEPTH    = 1 << FIFO_ADDRSIZE;

   typedef logic [PTR_W-1:0] ptr_t;

   // Generic 32-bit conversion; callers truncate the result to their pointer width.
   function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
      return i_bin ^ (i_bin >> 1);
   endfunction

endpackage

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Combinational Gray to binary converter. Each binary bit is the XOR of all
// Gray bits from the MSB down to that bit position.
//   i_gray : Gray-coded input, WIDTH bits
//   o_bin  : binary output, WIDTH bits
// -----------------------------------------------------------------------------
module gray2bin #(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
   end

endmodule

// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
// Write-domain pointer and status controller for the async FIFO. Keeps the
// binary write address and Gray write pointer, and derives full, almost-full,
// fill level and a sticky overflow flag from the synchronised read pointer.
//   wclk         : write-domain clock
//   wrst         : synchronous active-high reset
//   winc         : write request from the producer
//   wovf_clr     : clears the sticky overflow flag
//   wq2_rptr     : Gray read pointer synchronised into wclk
//   wptr         : registered Gray write pointer (to the write-to-read sync)
//   waddr        : memory write address
//   wclken       : memory write enable (combinational)
//   wfull        : registered full flag
//   walmost_full : registered, level >= AF_THRESH
//   wlevel       : registered fill level, 0..2^ADDRSIZE
//   woverflow    : sticky flag, write attempted while full
// -----------------------------------------------------------------------------
module wptr_full_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDRSIZE  = FIFO_ADDRSIZE,
   parameter int unsigned AF_THRESH = 12
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic                wovf_clr,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   output logic [ADDRSIZE:0]   wptr,
   output logic [ADDRSIZE-1:0] waddr,
   output logic                wclken,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                woverflow
);

   localparam int unsigned PW = ADDRSIZE + 1;
   localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

   logic [PW-1:0] r_wbin;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_wlevel;
   logic          r_wfull;
   logic          r_walmost_full;
   logic          r_woverflow;

   logic          w_accept;
   logic [PW-1:0] w_wbinnext;
   logic [PW-1:0] w_wgraynext;
   logic [PW-1:0] w_rbin_s;
   logic [PW-1:0] w_lvl_next;
   logic [PW-1:0] w_full_ptr;
   logic          w_full_next;

   // A write while full is dropped, so the pointer only advances on acceptance.
   assign w_accept    = winc & ~r_wfull;
   assign w_wbinnext  = r_wbin + {{(PW-1){1'b0}}, w_accept};
   assign w_wgraynext = PW'(bin2gray(32'(w_wbinnext)));

   gray2bin #(
      .WIDTH (PW)
   ) u_gray2bin (
      .i_gray (wq2_rptr),
      .o_bin  (w_rbin_s)
   );

   // Modulo 2^(ADDRSIZE+1) subtraction gives the occupancy across pointer wrap.
   assign w_lvl_next = w_wbinnext - w_rbin_s;

   // Full when the write pointer has lapped the read pointer exactly once:
   // in Gray code that is the read pointer with its two MSBs inverted.
   assign w_full_ptr  = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
   assign w_full_next = (w_wgraynext == w_full_ptr);

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_wbin         <= '0;
         r_wptr         <= '0;
         r_wlevel       <= '0;
         r_wfull        <= 1'b0;
         r_walmost_full <= 1'b0;
         r_woverflow    <= 1'b0;
      end else begin
         r_wbin         <= w_wbinnext;
         r_wptr         <= w_wgraynext;
         r_wlevel       <= w_lvl_next;
         r_wfull        <= w_full_next;
         r_walmost_full <= (w_lvl_next >= AF_LVL);
         // Set term is OR-ed last so a new overflow wins over a coincident clear.
         r_woverflow    <= (r_woverflow & ~wovf_clr) | (winc & r_wfull);
      end
   end

   // Reset gates the enable so a write presented during reset never hits memory.
   assign wclken       = winc & ~r_wfull & ~wrst;
   assign wptr         = r_wptr;
   assign waddr        = r_wbin[ADDRSIZE-1:0];
   assign wfull        = r_wfull;
   assign walmost_full = r_walmost_full;
   assign wlevel       = r_wlevel;
   assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_ctrl
// Self-checking bench for wptr_full_ctrl (ADDRSIZE=4, AF_THRESH=12).
// The step task drives one cycle of stimulus, advances a behavioural model that
// counts accepted writes, and pushes the expected post-edge outputs to a
// scoreboard queue; a monitor pops and compares them after each rising edge.
// Scenario tasks add targeted checks against fixed expected values.
// -----------------------------------------------------------------------------
module tb_wptr_full_ctrl;

   localparam int AS = 4;
   localparam int PW = AS + 1;

   logic          wclk = 1'b0;
   logic          wrst = 1'b1;
   logic          winc = 1'b0;
   logic          wovf_clr = 1'b0;
   logic [PW-1:0] wq2_rptr = '0;
   logic [PW-1:0] wptr;
   logic [AS-1:0] waddr;
   logic          wclken;
   logic          wfull;
   logic          walmost_full;
   logic [PW-1:0] wlevel;
   logic          woverflow;

   always #5 wclk = ~wclk;

   wptr_full_ctrl #(
      .ADDRSIZE  (AS),
      .AF_THRESH (12)
   ) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .winc         (winc),
      .wovf_clr     (wovf_clr),
      .wq2_rptr     (wq2_rptr),
      .wptr         (wptr),
      .waddr        (waddr),
      .wclken       (wclken),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .woverflow    (woverflow)
   );

   typedef struct {
      logic [PW-1:0] wptr;
      logic [AS-1:0] waddr;
      logic          wfull;
      logic          waf;
      logic [PW-1:0] wlevel;
      logic          wovf;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Behavioural model: write count is an unbounded integer.
   int   m_wcount = 0;
   int   m_level  = 0;
   logic m_full   = 1'b0;
   logic m_af     = 1'b0;
   logic m_ovf    = 1'b0;

   function automatic logic [PW-1:0] to_gray(input int n);
      logic [PW-1:0] b;
      b = PW'(n);
      return b ^ (b >> 1);
   endfunction

   // One clock cycle of stimulus; returns 3 time units after the rising edge.
   task automatic step(input logic inc, input logic clr, input int rcnt, input logic rst);
      exp_t e;
      logic exp_en;
      winc     = inc;
      wovf_clr = clr;
      wrst     = rst;
      wq2_rptr = to_gray(rcnt);
      #1;
      exp_en = inc && !m_full && !rst;
      n_checks++;
      if (wclken !== exp_en)
         $display("FAIL wclken: observed %b expected %b at %0t", wclken, exp_en, $time);
      else
         n_pass++;
      if (rst) begin
         m_wcount = 0;
         m_level  = 0;
         m_full   = 1'b0;
         m_af     = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         m_ovf = (m_ovf && !clr) || (inc && m_full);
         if (inc && !m_full) m_wcount++;
         m_level = m_wcount - rcnt;
         m_full  = (m_level == 16);
         m_af    = (m_level >= 12);
      end
      e.wptr   = to_gray(m_wcount);
      e.waddr  = AS'(m_wcount);
      e.wfull  = m_full;
      e.waf    = m_af;
      e.wlevel = PW'(m_level);
      e.wovf   = m_ovf;
      sb_q.push_back(e);
      @(posedge wclk);
      #3;
   endtask

   // Scoreboard monitor: compares registered outputs 2 units after each edge.
   always @(posedge wclk) begin
      #2;
      if (sb_q.size() > 0) begin : mon
         exp_t e;
         e = sb_q.pop_front();
         n_checks += 6;
         if (wptr !== e.wptr)
            $display("FAIL sb_wptr: observed %b expected %b at %0t", wptr, e.wptr, $time);
         else n_pass++;
         if (waddr !== e.waddr)
            $display("FAIL sb_waddr: observed %0d expected %0d at %0t", waddr, e.waddr, $time);
         else n_pass++;
         if (wfull !== e.wfull)
            $display("FAIL sb_wfull: observed %b expected %b at %0t", wfull, e.wfull, $time);
         else n_pass++;
         if (walmost_full !== e.waf)
            $display("FAIL sb_walmost_full: observed %b expected %b at %0t", walmost_full, e.waf, $time);
         else n_pass++;
         if (wlevel !== e.wlevel)
            $display("FAIL sb_wlevel: observed %0d expected %0d at %0t", wlevel, e.wlevel, $time);
         else n_pass++;
         if (woverflow !== e.wovf)
            $display("FAIL sb_woverflow: observed %b expected %b at %0t", woverflow, e.wovf, $time);
         else n_pass++;
      end
   end

   task automatic test_reset();
      step(1'b1, 1'b0, 0, 1'b1);
      step(1'b1, 1'b0, 0, 1'b1);
      n_checks++;
      if ({wptr, waddr, wfull, walmost_full, wlevel, woverflow} !== '0)
         $display("FAIL reset_outputs: observed wptr=%b waddr=%0d wfull=%b waf=%b wlevel=%0d wovf=%b expected all 0",
                  wptr, waddr, wfull, walmost_full, wlevel, woverflow);
      else n_pass++;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0, 0, 1'b0);
         if (i == 11) begin
            n_checks++;
            if (walmost_full !== 1'b0 || wlevel !== 5'd11)
               $display("FAIL fill_af_11: observed waf=%b wlevel=%0d expected waf=0 wlevel=11", walmost_full, wlevel);
            else n_pass++;
         end
         if (i == 12) begin
            n_checks++;
            if (walmost_full !== 1'b1 || wlevel !== 5'd12)
               $display("FAIL fill_af_12: observed waf=%b wlevel=%0d expected waf=1 wlevel=12", walmost_full, wlevel);
            else n_pass++;
         end
         if (i == 15) begin
            n_checks++;
            if (wfull !== 1'b0)
               $display("FAIL fill_notfull_15: observed wfull=%b expected 0", wfull);
            else n_pass++;
         end
      end
      n_checks++;
      if (wfull !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11000 || waddr !== 4'd0)
         $display("FAIL fill_full: observed wfull=%b wlevel=%0d wptr=%b waddr=%0d expected 1 16 11000 0",
                  wfull, wlevel, wptr, waddr);
      else n_pass++;
   endtask

   task automatic test_overflow();
      step(1'b1, 1'b0, 0, 1'b0);
      n_checks++;
      if (wptr !== 5'b11000 || woverflow !== 1'b1)
         $display("FAIL ovf_set: observed wptr=%b woverflow=%b expected 11000 1", wptr, woverflow);
      else n_pass++;
      step(1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 1'b0, 0, 1'b0);
      n_checks++;
      if (woverflow !== 1'b1)
         $display("FAIL ovf_sticky: observed %b expected 1", woverflow);
      else n_pass++;
      // Clear coinciding with a new overflow: set wins.
      step(1'b1, 1'b1, 0, 1'b0);
      n_checks++;
      if (woverflow !== 1'b1)
         $display("FAIL ovf_set_wins: observed %b expected 1", woverflow);
      else n_pass++;
      step(1'b0, 1'b1, 0, 1'b0);
      n_checks++;
      if (woverflow !== 1'b0)
         $display("FAIL ovf_clear: observed %b expected 0", woverflow);
      else n_pass++;
   endtask

   task automatic test_drain();
      step(1'b0, 1'b0, 1, 1'b0);
      n_checks++;
      if (wfull !== 1'b0 || wlevel !== 5'd15 || walmost_full !== 1'b1)
         $display("FAIL drain: observed wfull=%b wlevel=%0d waf=%b expected 0 15 1", wfull, wlevel, walmost_full);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      step(1'b1, 1'b0, 2, 1'b0);
      n_checks++;
      if (wlevel !== 5'd15 || wfull !== 1'b0 || wptr !== 5'b11001)
         $display("FAIL simultaneous: observed wlevel=%0d wfull=%b wptr=%b expected 15 0 11001", wlevel, wfull, wptr);
      else n_pass++;
   endtask

   task automatic test_wrap();
      // Reset with a write presented: the write is discarded.
      step(1'b1, 1'b0, 0, 1'b1);
      for (int i = 1; i <= 40; i++) begin
         step(1'b1, 1'b0, (i > 3) ? i - 3 : 0, 1'b0);
         n_checks++;
         if (wfull !== 1'b0 || wlevel > 5'd3)
            $display("FAIL wrap_status: write %0d observed wfull=%b wlevel=%0d expected 0 and <=3", i, wfull, wlevel);
         else n_pass++;
         if (i == 16 || i == 32) begin
            n_checks++;
            if (waddr !== 4'd0)
               $display("FAIL wrap_waddr: write %0d observed %0d expected 0", i, waddr);
            else n_pass++;
         end
         if (i == 31) begin
            n_checks++;
            if (wptr !== 5'b10000)
               $display("FAIL wrap_wptr_31: observed %b expected 10000", wptr);
            else n_pass++;
         end
         if (i == 32) begin
            n_checks++;
            if (wptr !== 5'b00000)
               $display("FAIL wrap_wptr_32: observed %b expected 00000", wptr);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_simultaneous();
      test_wrap();
      winc = 1'b0;
      @(posedge wclk);
      #5;
      n_checks++;
      if (sb_q.size() != 0)
         $display("FAIL sb_drained: observed %0d pending entries expected 0", sb_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
